// File: rtl/l0_ctrl_pkg.sv
// Shared types and defaults for the L0 input-FIFO sequencer.
// Holds the controller state encoding and the job-length clamp.
package l0_ctrl_pkg;

    localparam int unsigned def_row    = 8;
    localparam int unsigned def_addr_w = 11;
    localparam int unsigned def_depth  = 64;
    localparam int unsigned def_cnt_w  = 7;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StDrain,
        StTail,
        StDone
    } state_t;

    // Jobs longer than the FIFO are cut down to what L0 can hold.
    function automatic int unsigned clamp_vec(input int unsigned num_vec,
                                              input int unsigned depth);
        return (num_vec > depth) ? depth : num_vec;
    endfunction

endpackage

// File: rtl/l0_seq_ctrl_if.sv
// Job, SRAM and L0 handshake bundle between the sequencer and its environment.
// master = sequencer side, slave = the host/SRAM/L0 side.
interface l0_seq_ctrl_if
    import l0_ctrl_pkg::*;
#(
    parameter int unsigned addr_w = def_addr_w,
    parameter int unsigned cnt_w  = def_cnt_w
);
    logic              start;
    logic [addr_w-1:0] base_addr;
    logic [cnt_w-1:0]  num_vec;
    logic              array_ready;
    logic              l0_full;
    logic              sram_cen;
    logic              sram_wen;
    logic [addr_w-1:0] sram_addr;
    logic              l0_wr;
    logic              l0_rd;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, base_addr, num_vec, array_ready, l0_full,
        output sram_cen, sram_wen, sram_addr, l0_wr, l0_rd, busy, done, err
    );

    modport slave (
        output start, base_addr, num_vec, array_ready, l0_full,
        input  sram_cen, sram_wen, sram_addr, l0_wr, l0_rd, busy, done, err
    );

endinterface

// File: rtl/l0_step_cnt.sv
// Up-counter with synchronous clear (priority over enable) and a flag that is
// high while the count sits one below the terminal value.
module l0_step_cnt #(
    parameter int unsigned w = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [w-1:0] term,
    output logic [w-1:0] cnt,
    output logic         last
);

    logic [w-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + w'(1);
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == (term - w'(1)));

endmodule

// File: rtl/l0_seq_ctrl.sv
// Sequencer that loads a job of activation vectors from SRAM into the L0 FIFO
// bank, drains them into the MAC array, waits for the row stagger, then pulses done.
module l0_seq_ctrl
    import l0_ctrl_pkg::*;
#(
    parameter int unsigned row    = def_row,
    parameter int unsigned bw     = 4,
    parameter int unsigned addr_w = def_addr_w,
    parameter int unsigned depth  = def_depth,
    parameter int unsigned cnt_w  = def_cnt_w
) (
    input logic          clk,
    input logic          reset,
    l0_seq_ctrl_if.master bus
);

    localparam int unsigned tail_w = $clog2(row + 1);

    state_t            state_q, state_d;
    logic [addr_w-1:0] base_q;
    logic [cnt_w-1:0]  n_q;
    logic              issue_q, issue_d;
    logic              wr_q;
    logic              err_q;

    logic              job_go;
    logic [cnt_w-1:0]  n_new;
    logic [cnt_w-1:0]  wr_cnt, rd_cnt;
    logic [tail_w-1:0] tail_cnt;
    logic              wr_last, rd_last, tail_last;
    logic              rd_pulse;

    // Element width only matters to the data path, which bypasses this block.
    logic unused_bw;
    assign unused_bw = ^bw;

    assign job_go   = (state_q == StIdle) && bus.start && (bus.num_vec != '0);
    assign n_new    = cnt_w'(clamp_vec(32'(bus.num_vec), depth));
    assign rd_pulse = (state_q == StDrain) && bus.array_ready;

    l0_step_cnt #(.w(cnt_w)) u_wr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (job_go),
        .en    ((state_q == StLoad) && issue_q),
        .term  (n_q),
        .cnt   (wr_cnt),
        .last  (wr_last)
    );

    l0_step_cnt #(.w(cnt_w)) u_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (job_go),
        .en    (rd_pulse),
        .term  (n_q),
        .cnt   (rd_cnt),
        .last  (rd_last)
    );

    l0_step_cnt #(.w(tail_w)) u_tail_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != StTail),
        .en    (state_q == StTail),
        .term  (tail_w'(row)),
        .cnt   (tail_cnt),
        .last  (tail_last)
    );

    logic unused_cnt;
    assign unused_cnt = ^{rd_cnt, tail_cnt};

    // The issue decision is registered so sram_cen stays a Moore output; it
    // looks at l0_full one cycle ahead of the SRAM access it enables.
    always_comb begin
        state_d = state_q;
        issue_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.num_vec != '0) begin
                        state_d = StLoad;
                        issue_d = !bus.l0_full;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StLoad: begin
                if (issue_q && wr_last) begin
                    state_d = StWait;
                end else begin
                    issue_d = !bus.l0_full;
                end
            end
            StWait:  state_d = StDrain;
            StDrain: begin
                if (rd_pulse && rd_last) begin
                    state_d = StTail;
                end
            end
            StTail: begin
                if (tail_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            base_q  <= '0;
            n_q     <= '0;
            issue_q <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            wr_q    <= issue_q;
            err_q   <= err_q | (wr_q & bus.l0_full);
            if (job_go) begin
                base_q <= bus.base_addr;
                n_q    <= n_new;
            end
        end
    end

    assign bus.sram_cen  = !issue_q;
    assign bus.sram_wen  = 1'b1;
    assign bus.sram_addr = base_q + addr_w'(wr_cnt);
    assign bus.l0_wr     = wr_q;
    assign bus.l0_rd     = rd_pulse;
    assign bus.busy      = (state_q == StLoad) || (state_q == StWait) ||
                           (state_q == StDrain) || (state_q == StTail);
    assign bus.done      = (state_q == StDone);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_l0_seq_ctrl.sv
// Directed bench for l0_seq_ctrl: a timeline model derived from the job rules
// is compared against every output on every cycle, plus hand-computed pins.
module tb_l0_seq_ctrl;

    localparam int ROW    = 8;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 7;
    localparam int MAXC   = 200;

    logic clk;
    logic reset;

    l0_seq_ctrl_if #(.addr_w(ADDR_W), .cnt_w(CNT_W)) bus ();

    l0_seq_ctrl #(
        .row    (ROW),
        .bw     (4),
        .addr_w (ADDR_W),
        .depth  (DEPTH),
        .cnt_w  (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrs   = 0;
    int cyc     = 0;
    bit chk_on  = 1'b0;

    bit full_pat  [MAXC];
    bit ready_pat [MAXC];
    bit e_cen [MAXC];
    bit e_wr  [MAXC];
    bit e_rd  [MAXC];
    bit e_busy[MAXC];
    bit e_done[MAXC];
    bit e_err [MAXC];
    int e_addr[MAXC];
    int last_cyc;
    bit err_carry = 1'b0;

    int iss_cnt, rd_seen, done_cyc, busy_seen, last_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Expected timeline from the job rules: an issue happens in a cycle when
    // the previous cycle saw L0 not full; writes trail issues by one cycle;
    // reads start two cycles after the last issue and follow array_ready;
    // done comes row cycles after the last read.
    task automatic build_model(input int n_req, input int base, input int rst_at);
        int n, cnt, k, li, lr, dc;
        n  = (n_req > DEPTH) ? DEPTH : n_req;
        li = 0;
        lr = 0;
        for (int c = 0; c < MAXC; c++) begin
            e_cen[c] = 1'b1; e_wr[c] = 1'b0; e_rd[c] = 1'b0; e_busy[c] = 1'b0;
            e_done[c] = 1'b0; e_err[c] = 1'b0; e_addr[c] = 0;
        end
        if (n == 0) begin
            dc = 1;
        end else begin
            cnt = 0;
            k   = 1;
            while (cnt < n && k < MAXC - 1) begin
                if (!full_pat[k-1]) begin
                    e_cen[k]  = 1'b0;
                    e_addr[k] = (base + cnt) % (1 << ADDR_W);
                    e_wr[k+1] = 1'b1;
                    cnt++;
                    li = k;
                end
                k++;
            end
            cnt = 0;
            k   = li + 2;
            while (cnt < n && k < MAXC) begin
                if (ready_pat[k]) begin
                    e_rd[k] = 1'b1;
                    cnt++;
                    lr = k;
                end
                k++;
            end
            dc = lr + ROW + 1;
            if (dc > MAXC - 3) dc = MAXC - 3;
            for (int c = 1; c < dc; c++) e_busy[c] = 1'b1;
        end
        e_done[dc] = 1'b1;
        last_cyc = (rst_at >= 0) ? rst_at : dc + 1;
        e_err[0] = err_carry;
        for (int c = 0; c < MAXC - 1; c++) e_err[c+1] = e_err[c] | (e_wr[c] & full_pat[c]);
        err_carry = (rst_at >= 0) ? 1'b0 : e_err[last_cyc + 1];
    endtask

    task automatic run_job(input int n_req, input int base, input int rst_at);
        build_model(n_req, base, rst_at);
        iss_cnt = 0; rd_seen = 0; done_cyc = -1; busy_seen = 0; last_addr = -1;
        for (int c = 0; c <= last_cyc; c++) begin
            cyc             = c;
            bus.start       = (c == 0);
            bus.num_vec     = CNT_W'(n_req);
            bus.base_addr   = ADDR_W'(base);
            bus.l0_full     = full_pat[c];
            bus.array_ready = ready_pat[c];
            reset           = (c == rst_at);
            chk_on          = 1'b1;
            @(posedge clk);
            #1;
        end
        chk_on      = 1'b0;
        bus.start   = 1'b0;
        reset       = 1'b0;
        bus.l0_full = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            full_pat[c]  = 1'b0;
            ready_pat[c] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("sram_cen", 32'(bus.sram_cen), 32'(e_cen[cyc]));
            check("sram_wen", 32'(bus.sram_wen), 32'd1);
            check("l0_wr",    32'(bus.l0_wr),    32'(e_wr[cyc]));
            check("l0_rd",    32'(bus.l0_rd),    32'(e_rd[cyc]));
            check("busy",     32'(bus.busy),     32'(e_busy[cyc]));
            check("done",     32'(bus.done),     32'(e_done[cyc]));
            check("err",      32'(bus.err),      32'(e_err[cyc]));
            if (!e_cen[cyc]) check("sram_addr", 32'(bus.sram_addr), 32'(e_addr[cyc]));
            if (!bus.sram_cen) begin
                iss_cnt++;
                last_addr = int'(bus.sram_addr);
            end
            if (bus.l0_rd) rd_seen++;
            if (bus.done)  done_cyc = cyc;
            if (bus.busy)  busy_seen++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cen"},  32'(bus.sram_cen),  32'd1);
        check({tag, "_wen"},  32'(bus.sram_wen),  32'd1);
        check({tag, "_addr"}, 32'(bus.sram_addr), 32'd0);
        check({tag, "_wr"},   32'(bus.l0_wr),     32'd0);
        check({tag, "_rd"},   32'(bus.l0_rd),     32'd0);
        check({tag, "_busy"}, 32'(bus.busy),      32'd0);
        check({tag, "_done"}, 32'(bus.done),      32'd0);
        check({tag, "_err"},  32'(bus.err),       32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.base_addr   = '0;
        bus.num_vec     = '0;
        bus.l0_full     = 1'b0;
        bus.array_ready = 1'b1;
        for (int c = 0; c < MAXC; c++) begin
            full_pat[c]  = 1'b0;
            ready_pat[c] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Nominal job, N=4
        run_job(4, 'h010, -1);
        check("t1_done_cycle", 32'(done_cyc),  32'd18);
        check("t1_issues",     32'(iss_cnt),   32'd4);
        check("t1_reads",      32'(rd_seen),   32'd4);
        check("t1_last_addr",  32'(last_addr), 32'h013);
        check("t1_busy_cyc",   32'(busy_seen), 32'd17);

        // Empty job
        run_job(0, 'h123, -1);
        check("t2_done_cycle", 32'(done_cyc),  32'd1);
        check("t2_issues",     32'(iss_cnt),   32'd0);
        check("t2_busy_cyc",   32'(busy_seen), 32'd0);

        // Clamp to depth with address wrap
        run_job(100, 'h7F0, -1);
        check("t3_issues",     32'(iss_cnt),   32'd64);
        check("t3_reads",      32'(rd_seen),   32'd64);
        check("t3_last_addr",  32'(last_addr), 32'h02F);
        check("t3_done_cycle", 32'(done_cyc),  32'd138);

        // array_ready toggling during DRAIN, N=3 (DRAIN starts at cycle 5)
        ready_pat[5] = 1'b1; ready_pat[6] = 1'b0; ready_pat[7] = 1'b1;
        ready_pat[8] = 1'b0; ready_pat[9] = 1'b1;
        run_job(3, 'h200, -1);
        check("t4_reads",      32'(rd_seen),  32'd3);
        check("t4_done_cycle", 32'(done_cyc), 32'd18);

        // l0_full high on cycles 2..4 of the load
        full_pat[2] = 1'b1; full_pat[3] = 1'b1; full_pat[4] = 1'b1;
        run_job(4, 'h100, -1);
        check("t5_issues",     32'(iss_cnt),   32'd4);
        check("t5_err",        32'(bus.err),   32'd1);
        check("t5_done_cycle", 32'(done_cyc),  32'd21);
        check("t5_last_addr",  32'(last_addr), 32'h103);

        // Reset in the middle of DRAIN (cycle 7), then a fresh N=2 job
        run_job(4, 'h020, 7);
        bus.array_ready = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid");
        @(posedge clk);
        #1;
        run_job(2, 'h040, -1);
        check("t6_done_cycle", 32'(done_cyc), 32'd14);
        check("t6_reads",      32'(rd_seen),  32'd2);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
